// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
// Scans a 4x4 active-low keypad matrix one column at a time, debounces the
// row sense lines and emits one pulse per accepted key press. The key code is
// {row_idx, col_idx}. Codes 8..15 (rows 2-3) are X coordinates and codes
// 0..7 (rows 0-1) are Y coordinates for the position-entry logic.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous reset, active low
//   en            scan enable; low parks the matrix and returns to IDLE
//   keyboard_row  row sense, active low, asynchronous to clk (bit 3 = row0)
//   keyboard_col  column drive, one-hot low (col0 = 4'b0111 ... col3 = 4'b1110)
//   key_valid     one-cycle pulse; key_code is valid in the same cycle
//   key_code      {row_idx, col_idx}; held until the next accepted press
//   key_down      high from key_valid until the release is debounced
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | matrix parked (all columns high), counters cleared
// SCAN     | walking the columns, one SCAN_DIV slot each
// DEBOUNCE | column frozen, counting identical row samples
// HOLD     | key accepted, column frozen, counting released samples
module keypad_matrix_scanner #(
  parameter int SCAN_DIV     = 50,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] keyboard_row,
  output logic [3:0] keyboard_col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_down
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CNT - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SCAN     = 2'd1;
  localparam logic [1:0] ST_DEBOUNCE = 2'd2;
  localparam logic [1:0] ST_HOLD     = 2'd3;

  logic [1:0]    state;
  logic [SW-1:0] slot_cnt;
  logic [1:0]    col_idx;
  logic [CW-1:0] match_cnt;
  logic [CW-1:0] rel_cnt;
  logic [3:0]    pattern;
  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic          sample;
  logic          row_none;

  // Lowest row index wins; row0 is on bit 3 to mirror the column drive order.
  function automatic logic [1:0] row_enc(input logic [3:0] r);
    if (!r[3])      row_enc = 2'd0;
    else if (!r[2]) row_enc = 2'd1;
    else if (!r[1]) row_enc = 2'd2;
    else            row_enc = 2'd3;
  endfunction

  assign sample   = (state != ST_IDLE) && (slot_cnt == SLOT_LAST);
  assign row_none = (row_sync == 4'hF);

  assign keyboard_col = (state == ST_IDLE) ? 4'hF : ~(4'b1000 >> col_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= keyboard_row;
      row_sync <= row_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      slot_cnt  <= '0;
      col_idx   <= 2'd0;
      match_cnt <= '0;
      rel_cnt   <= '0;
      pattern   <= 4'hF;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (!en) begin
        // key_code is deliberately kept so the last accepted key stays readable.
        state     <= ST_IDLE;
        slot_cnt  <= '0;
        col_idx   <= 2'd0;
        match_cnt <= '0;
        rel_cnt   <= '0;
        key_down  <= 1'b0;
      end else begin
        if (state != ST_IDLE)
          slot_cnt <= sample ? '0 : slot_cnt + SW'(1);

        case (state)
          ST_IDLE: begin
            state    <= ST_SCAN;
            slot_cnt <= '0;
            col_idx  <= 2'd0;
          end

          ST_SCAN: begin
            if (sample) begin
              if (row_none) begin
                col_idx <= col_idx + 2'd1;
              end else begin
                pattern   <= row_sync;
                match_cnt <= CW'(1);
                state     <= ST_DEBOUNCE;
              end
            end
          end

          ST_DEBOUNCE: begin
            if (sample) begin
              if (row_none) begin
                state     <= ST_SCAN;
                col_idx   <= col_idx + 2'd1;
                match_cnt <= '0;
              end else if (row_sync != pattern) begin
                pattern   <= row_sync;
                match_cnt <= CW'(1);
              end else if (match_cnt == CNT_LAST) begin
                // This sample is the last matching one needed: accept the key.
                state     <= ST_HOLD;
                key_valid <= 1'b1;
                key_code  <= {row_enc(row_sync), col_idx};
                key_down  <= 1'b1;
                match_cnt <= '0;
                rel_cnt   <= '0;
              end else begin
                match_cnt <= match_cnt + CW'(1);
              end
            end
          end

          ST_HOLD: begin
            if (sample) begin
              if (row_none) begin
                if (rel_cnt == CNT_LAST) begin
                  key_down <= 1'b0;
                  state    <= ST_SCAN;
                  col_idx  <= col_idx + 2'd1;
                  rel_cnt  <= '0;
                end else begin
                  rel_cnt <= rel_cnt + CW'(1);
                end
              end else begin
                rel_cnt <= '0;
              end
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner
// Directed bench for keypad_matrix_scanner with a combinational keypad
// emulator. Expected key codes are queued when a press is staged and are
// compared whenever the scanner pulses key_valid.
module tb_keypad_matrix_scanner;

  localparam int SD = 50;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  keyboard_row;
  logic [3:0]  keyboard_col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_down;

  logic [15:0] pressed;
  logic [3:0]  sb[$];
  logic [3:0]  want;
  int          total = 0;
  int          bad   = 0;
  int          npulse = 0;
  int          p0;

  always #5 clk = ~clk;

  keypad_matrix_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .keyboard_row (keyboard_row),
    .keyboard_col (keyboard_col),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_down     (key_down)
  );

  // Key (r,c) pulls row r (bit 3-r) low while column c (bit 3-c) is driven low.
  always_comb begin
    keyboard_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !keyboard_col[3-c])
          keyboard_row[3-r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic slots(input int n);
    repeat (n * SD) @(negedge clk);
  endtask

  task automatic wait_down(input logic v, input string tag);
    for (int i = 0; i < 20 * SD && key_down !== v; i++) @(negedge clk);
    chk(tag, 32'(key_down), 32'(v));
  endtask

  task automatic wait_col(input logic [3:0] c, input string tag);
    for (int i = 0; i < 10 * SD && keyboard_col !== c; i++) @(negedge clk);
    chk(tag, 32'(keyboard_col), 32'(c));
  endtask

  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      npulse++;
      chk("pulse_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        want = sb.pop_front();
        chk("key_code", 32'(key_code), 32'(want));
      end
      chk("down_with_valid", 32'(key_down), 32'd1);
    end
  end

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    pressed = 16'h0;
    repeat (3) @(negedge clk);
    chk("reset_col",   32'(keyboard_col), 32'hF);
    chk("reset_valid", 32'(key_valid),    32'd0);
    chk("reset_code",  32'(key_code),     32'd0);
    chk("reset_down",  32'(key_down),     32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_col", 32'(keyboard_col), 32'hF);

    // T1: hold 4'hA (row2, col2)
    en = 1'b1;
    @(negedge clk);
    chk("scan_col0", 32'(keyboard_col), 32'h7);
    p0 = npulse;
    sb.push_back(4'hA);
    pressed[10] = 1'b1;
    wait_down(1'b1, "t1_down");
    chk("t1_col", 32'(keyboard_col), 32'hD);
    slots(20);
    chk("t1_col_held", 32'(keyboard_col), 32'hD);
    chk("t1_pulses", 32'(npulse - p0), 32'd1);
    pressed = 16'h0;
    repeat (3 * SD - 5) @(negedge clk);
    chk("t1_down_still", 32'(key_down), 32'd1);
    repeat (2 * SD + 5) @(negedge clk);
    chk("t1_down_fell", 32'(key_down), 32'd0);

    // T2: 4'h3 (row0, col3) pressed for two slots only
    p0 = npulse;
    wait_col(4'b1110, "t2_at_col3");
    pressed[3] = 1'b1;
    slots(2);
    pressed = 16'h0;
    wait_col(4'b0111, "t2_wrap_col0");
    slots(4);
    chk("t2_no_pulse", 32'(npulse - p0), 32'd0);

    // T3: 4'h5 and 4'h9 together in col1, row1 wins
    p0 = npulse;
    sb.push_back(4'h5);
    pressed[5] = 1'b1;
    pressed[9] = 1'b1;
    wait_down(1'b1, "t3_down");
    chk("t3_col", 32'(keyboard_col), 32'hB);
    slots(6);
    pressed = 16'h0;
    wait_down(1'b0, "t3_up");
    chk("t3_pulses", 32'(npulse - p0), 32'd1);

    // T4: 4'hF press / release / press
    p0 = npulse;
    sb.push_back(4'hF);
    sb.push_back(4'hF);
    pressed[15] = 1'b1;
    slots(10);
    chk("t4_down1", 32'(key_down), 32'd1);
    pressed = 16'h0;
    slots(10);
    chk("t4_up1", 32'(key_down), 32'd0);
    pressed[15] = 1'b1;
    slots(10);
    chk("t4_down2", 32'(key_down), 32'd1);
    pressed = 16'h0;
    wait_down(1'b0, "t4_up2");
    chk("t4_pulses", 32'(npulse - p0), 32'd2);

    // T5: en dropped mid-debounce of 4'h6 (row1, col2)
    p0 = npulse;
    wait_col(4'b1101, "t5_at_col2");
    pressed[6] = 1'b1;
    repeat (5 * SD / 2) @(negedge clk);
    chk("t5_debounce_col", 32'(keyboard_col), 32'hD);
    chk("t5_debounce_down", 32'(key_down), 32'd0);
    en = 1'b0;
    @(negedge clk);
    chk("t5_idle_col", 32'(keyboard_col), 32'hF);
    chk("t5_code_kept", 32'(key_code), 32'hF);
    slots(4);
    chk("t5_no_pulse", 32'(npulse - p0), 32'd0);
    pressed = 16'h0;
    en = 1'b1;
    @(negedge clk);
    chk("t5_restart_col0", 32'(keyboard_col), 32'h7);

    // T6: reset pulsed during HOLD of 4'hC (row3, col0)
    p0 = npulse;
    sb.push_back(4'hC);
    pressed[12] = 1'b1;
    wait_down(1'b1, "t6_down");
    slots(2);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_col",   32'(keyboard_col), 32'hF);
    chk("t6_rst_valid", 32'(key_valid),    32'd0);
    chk("t6_rst_code",  32'(key_code),     32'd0);
    chk("t6_rst_down",  32'(key_down),     32'd0);
    sb.push_back(4'hC);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_down(1'b1, "t6_redown");
    chk("t6_code", 32'(key_code), 32'hC);
    pressed = 16'h0;
    wait_down(1'b0, "t6_up");
    chk("t6_pulses", 32'(npulse - p0), 32'd2);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
